sc_regshift_tx: RTL and testbench
=================================

# sc_regshift_tx

Parallel-in/serial-out transmitter for the microdatapath. It captures a DATAWIDTH_BUS-wide word from a general register output bus on a load strobe, then shifts the word out MSB-first, one bit per clock, with a valid qualifier and an end-of-word pulse. It is the reading end of the general register: a register is written by the datapath, and this block reads it and serializes it to an off-datapath consumer (LED chain, debug probe, serial link). All state updates on the falling clock edge, the same edge the datapath registers use, so a register value written on edge n can be loaded on edge n+1.

## Interface
Parameters:
- DATAWIDTH_BUS, 32, width of the parallel word and of the shift register (≥2).
- DATA_SHIFT_INIT, 32'h00000000, reset value of the shift register.

Ports:
- SC_RegSHIFTTX_CLOCK_50  in  1  system clock; all state changes on negedge.
- SC_RegGENERAL_Reset_InHigh  in  1  reset, asynchronous, active-high.
- SC_RegSHIFTTX_Load_InHigh  in  1  load strobe; sampled on negedge, honoured only in IDLE.
- SC_RegSHIFTTX_DataBUS_In  in  DATAWIDTH_BUS  parallel word, driven by a general register output.
- SC_RegSHIFTTX_Serial_Out  out  1  current serial bit; forced 0 outside SHIFT.
- SC_RegSHIFTTX_Valid_Out  out  1  high while Serial_Out carries a data bit.
- SC_RegSHIFTTX_Ready_Out  out  1  high in IDLE: a load will be accepted.
- SC_RegSHIFTTX_Done_Out  out  1  one-cycle pulse after the last bit.
- SC_RegSHIFTTX_DataBUS_Out  out  DATAWIDTH_BUS  live shift register contents, for debug.

## Operation
- Internal state: a 2-bit FSM, a DATAWIDTH_BUS shift register and a bit counter of width $clog2(DATAWIDTH_BUS).
- FSM states: IDLE, SHIFT and DONE.
  - IDLE → SHIFT when Load=1 on a negedge. Shift register ← DataBUS_In and counter ← 0 on that edge.
  - IDLE with Load=0: hold. Shift register and counter keep their values.
  - SHIFT with counter < DATAWIDTH_BUS-1: shift register ← {sr[W-2:0],1'b0} and counter ← counter+1 on each negedge.
  - SHIFT with counter = DATAWIDTH_BUS-1: go to DONE and perform the same shift, so the register ends all-zero.
  - DONE → IDLE unconditionally on the next negedge.
- Outputs are decoded combinationally from state, not registered:
  - Serial_Out = sr[W-1] in SHIFT, else 0.
  - Valid_Out = (state==SHIFT).
  - Ready_Out = (state==IDLE).
  - Done_Out = (state==DONE).
  - DataBUS_Out = sr at all times.
- Load is ignored in SHIFT and DONE. It is not queued, and DataBUS_In changes during a transfer have no effect.
- Load held high continuously gives back-to-back words with a one-cycle DONE gap. The new word is captured on the DONE→IDLE edge+1, that is, the first edge spent in IDLE.
- Unused state encoding (2'b11) → IDLE on the next negedge.

## Timing
- Reset (async, any time, including mid-word):
  - state=IDLE, sr=DATA_SHIFT_INIT, counter=0.
  - Serial_Out=0, Valid_Out=0, Done_Out=0, Ready_Out=1, DataBUS_Out=DATA_SHIFT_INIT.
  - A partial word is discarded and no Done pulse is produced.
- Load sampled at negedge k:
  - Valid_Out rises immediately after edge k.
  - Bit i (MSB = bit W-1 first) is present from edge k+i to edge k+i+1, for i = 0..W-1.
- Done_Out is high from edge k+W to edge k+W+1. Ready_Out returns after edge k+W+1.
- Word period: W+1 cycles of transfer plus at least 1 IDLE cycle. Minimum load-to-load spacing is W+2 negedges.
- Reset deasserted between edges: the first active edge afterwards behaves as IDLE.

## Test plan
- Reset mid-word: async reset asserted mid-SHIFT (between edges) → outputs go to reset values immediately, with no Done pulse. A load 2 cycles after release transmits correctly.
- Basic word: load 32'hA5000001 at edge k → Serial_Out over edges k..k+31 reads 1,0,1,0,0,1,0,1, then 23×0, then 1. Valid high for exactly 32 cycles, Done high for 1 cycle at k+32, Ready high again after k+33.
- Load ignored while busy: during SHIFT, pulse Load with 32'hFFFFFFFF → serialized stream is unchanged and no extra Done pulse follows.
- Back-to-back: Load held high with 32'h80000000 then 32'h00000001 → first stream is 1 then 31×0, Done, one IDLE cycle, then second stream of 31×0 then 1. Exactly 2 Done pulses.
- Width and init parameters: DATAWIDTH_BUS=8, DATA_SHIFT_INIT=8'h3C → DataBUS_Out=8'h3C after reset. Loading 8'hC3 yields 1,1,0,0,0,0,1,1 over 8 cycles, and DataBUS_Out=8'h00 in DONE.

Source files
------------

// File: rtl/sc_regshift_tx_if.sv
// Handshake and data bundle between a general-register reader and the
// serial transmitter. The master drives load/word; the slave (transmitter) drives the rest.
interface sc_regshift_tx_if #(
    parameter int DATAWIDTH_BUS = 32
);
    logic                     SC_RegSHIFTTX_Load_InHigh;
    logic [DATAWIDTH_BUS-1:0] SC_RegSHIFTTX_DataBUS_In;
    logic                     SC_RegSHIFTTX_Serial_Out;
    logic                     SC_RegSHIFTTX_Valid_Out;
    logic                     SC_RegSHIFTTX_Ready_Out;
    logic                     SC_RegSHIFTTX_Done_Out;
    logic [DATAWIDTH_BUS-1:0] SC_RegSHIFTTX_DataBUS_Out;

    modport master (
        output SC_RegSHIFTTX_Load_InHigh,
        output SC_RegSHIFTTX_DataBUS_In,
        input  SC_RegSHIFTTX_Serial_Out,
        input  SC_RegSHIFTTX_Valid_Out,
        input  SC_RegSHIFTTX_Ready_Out,
        input  SC_RegSHIFTTX_Done_Out,
        input  SC_RegSHIFTTX_DataBUS_Out
    );

    modport slave (
        input  SC_RegSHIFTTX_Load_InHigh,
        input  SC_RegSHIFTTX_DataBUS_In,
        output SC_RegSHIFTTX_Serial_Out,
        output SC_RegSHIFTTX_Valid_Out,
        output SC_RegSHIFTTX_Ready_Out,
        output SC_RegSHIFTTX_Done_Out,
        output SC_RegSHIFTTX_DataBUS_Out
    );
endinterface

// File: rtl/sc_regshift_tx.sv
// Parallel-in/serial-out transmitter: captures a general-register word and
// shifts it out MSB-first on the falling edge, with valid/ready/done qualifiers.
module sc_regshift_tx #(
    parameter int                       DATAWIDTH_BUS   = 32,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_SHIFT_INIT = '0
) (
    input  logic            SC_RegSHIFTTX_CLOCK_50,
    input  logic            SC_RegGENERAL_Reset_InHigh,
    sc_regshift_tx_if.slave txIf
);
    localparam int               CNT_W    = $clog2(DATAWIDTH_BUS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATAWIDTH_BUS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } stateType;

    stateType                 stateReg, stateNext;
    logic [DATAWIDTH_BUS-1:0] shiftReg, shiftNext;
    logic [DATAWIDTH_BUS-1:0] shiftedWord;
    logic [CNT_W-1:0]         countReg, countNext;

    // Left shift with zero fill, so the register drains to all-zero by DONE.
    assign shiftedWord[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < DATAWIDTH_BUS; gi++) begin : g_shift
            assign shiftedWord[gi] = shiftReg[gi-1];
        end
    endgenerate

    // Falling edge matches the datapath registers, so a word written on one
    // edge can be loaded on the next.
    always_ff @(negedge SC_RegSHIFTTX_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
        if (SC_RegGENERAL_Reset_InHigh) begin
            stateReg <= IDLE;
            shiftReg <= DATA_SHIFT_INIT;
            countReg <= '0;
        end else begin
            stateReg <= stateNext;
            shiftReg <= shiftNext;
            countReg <= countNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        shiftNext = shiftReg;
        countNext = countReg;
        case (stateReg)
            IDLE: begin
                if (txIf.SC_RegSHIFTTX_Load_InHigh) begin
                    stateNext = SHIFT;
                    shiftNext = txIf.SC_RegSHIFTTX_DataBUS_In;
                    countNext = '0;
                end
            end
            SHIFT: begin
                shiftNext = shiftedWord;
                if (countReg == CNT_LAST) begin
                    stateNext = DONE;
                end else begin
                    countNext = countReg + 1'b1;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign txIf.SC_RegSHIFTTX_Serial_Out  = (stateReg == SHIFT) & shiftReg[DATAWIDTH_BUS-1];
    assign txIf.SC_RegSHIFTTX_Valid_Out   = (stateReg == SHIFT);
    assign txIf.SC_RegSHIFTTX_Ready_Out   = (stateReg == IDLE);
    assign txIf.SC_RegSHIFTTX_Done_Out    = (stateReg == DONE);
    assign txIf.SC_RegSHIFTTX_DataBUS_Out = shiftReg;
endmodule

// File: tb/tb_sc_regshift_tx.sv
// Scoreboard bench for sc_regshift_tx: a 32-bit and an 8-bit instance, expected
// serial bits queued at load time and popped by per-instance monitors.
module tb_sc_regshift_tx;
    logic clk;
    logic rst32;
    logic rst8;

    sc_regshift_tx_if #(.DATAWIDTH_BUS(32)) if32 ();
    sc_regshift_tx_if #(.DATAWIDTH_BUS(8))  if8 ();

    sc_regshift_tx #(
        .DATAWIDTH_BUS(32),
        .DATA_SHIFT_INIT(32'h00000000)
    ) dut32 (
        .SC_RegSHIFTTX_CLOCK_50(clk),
        .SC_RegGENERAL_Reset_InHigh(rst32),
        .txIf(if32)
    );

    sc_regshift_tx #(
        .DATAWIDTH_BUS(8),
        .DATA_SHIFT_INIT(8'h3C)
    ) dut8 (
        .SC_RegSHIFTTX_CLOCK_50(clk),
        .SC_RegGENERAL_Reset_InHigh(rst8),
        .txIf(if8)
    );

    int   nCompared = 0;
    int   nMismatch = 0;
    int   done32    = 0;
    int   done8     = 0;
    int   run32     = 0;
    int   run8      = 0;
    logic expQ32[$];
    logic expQ8[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitors sample on the rising edge, half a cycle away from the active falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst32) begin
                run32 = 0;
            end else begin
                if (if32.SC_RegSHIFTTX_Valid_Out) begin
                    run32++;
                    if (expQ32.size() == 0) check("unexpected_bit32", 64'd1, 64'd0);
                    else check("bit32", 64'(if32.SC_RegSHIFTTX_Serial_Out), 64'(expQ32.pop_front()));
                end
                if (if32.SC_RegSHIFTTX_Done_Out) begin
                    done32++;
                    check("valid_len32", 64'(run32), 64'd32);
                    run32 = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rst8) begin
                run8 = 0;
            end else begin
                if (if8.SC_RegSHIFTTX_Valid_Out) begin
                    run8++;
                    if (expQ8.size() == 0) check("unexpected_bit8", 64'd1, 64'd0);
                    else check("bit8", 64'(if8.SC_RegSHIFTTX_Serial_Out), 64'(expQ8.pop_front()));
                end
                if (if8.SC_RegSHIFTTX_Done_Out) begin
                    done8++;
                    check("valid_len8", 64'(run8), 64'd8);
                    run8 = 0;
                end
            end
        end
    end

    task automatic push32(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) expQ32.push_back(w[i]);
    endtask

    task automatic send32(input logic [31:0] w);
        @(posedge clk); #1;
        if32.SC_RegSHIFTTX_DataBUS_In  = w;
        if32.SC_RegSHIFTTX_Load_InHigh = 1'b1;
        push32(w);
        @(posedge clk); #1;
        if32.SC_RegSHIFTTX_Load_InHigh = 1'b0;
    endtask

    // Returns on the rising edge where Done is visible; bounded.
    task automatic waitDone(input int which);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clk);
            hit = (which == 32) ? if32.SC_RegSHIFTTX_Done_Out : if8.SC_RegSHIFTTX_Done_Out;
        end
        if (!hit) check("timeout_done", 64'd0, 64'd1);
    endtask

    int dRef;

    initial begin
        rst32 = 1'b1;
        rst8  = 1'b1;
        if32.SC_RegSHIFTTX_Load_InHigh = 1'b0;
        if32.SC_RegSHIFTTX_DataBUS_In  = '0;
        if8.SC_RegSHIFTTX_Load_InHigh  = 1'b0;
        if8.SC_RegSHIFTTX_DataBUS_In   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready32",  64'(if32.SC_RegSHIFTTX_Ready_Out),  64'd1);
        check("rst_valid32",  64'(if32.SC_RegSHIFTTX_Valid_Out),  64'd0);
        check("rst_serial32", 64'(if32.SC_RegSHIFTTX_Serial_Out), 64'd0);
        check("rst_done32",   64'(if32.SC_RegSHIFTTX_Done_Out),   64'd0);
        check("rst_data32",   64'(if32.SC_RegSHIFTTX_DataBUS_Out), 64'h0);
        check("rst_ready8",   64'(if8.SC_RegSHIFTTX_Ready_Out),   64'd1);
        check("rst_data8",    64'(if8.SC_RegSHIFTTX_DataBUS_Out), 64'h3C);
        rst32 = 1'b0;
        rst8  = 1'b0;
        repeat (2) @(posedge clk);

        // Basic word: 1,0,1,0,0,1,0,1, 23 zeros, 1
        send32(32'hA5000001);
        waitDone(32);
        #1;
        check("done_data32", 64'(if32.SC_RegSHIFTTX_DataBUS_Out), 64'h0);
        check("done_ready32", 64'(if32.SC_RegSHIFTTX_Ready_Out), 64'd0);
        @(posedge clk); #1;
        check("ready_after_done32", 64'(if32.SC_RegSHIFTTX_Ready_Out), 64'd1);
        check("done_count_basic", 64'(done32), 64'd1);

        // Load pulsed while busy must be ignored
        send32(32'h12345678);
        repeat (3) @(posedge clk);
        #1;
        if32.SC_RegSHIFTTX_DataBUS_In  = 32'hFFFFFFFF;
        if32.SC_RegSHIFTTX_Load_InHigh = 1'b1;
        @(posedge clk); #1;
        if32.SC_RegSHIFTTX_Load_InHigh = 1'b0;
        waitDone(32);
        repeat (40) @(posedge clk);
        #1;
        check("done_count_busy", 64'(done32), 64'd2);
        check("q32_empty_busy", 64'(expQ32.size()), 64'd0);

        // Asynchronous reset mid-word
        send32(32'hDEADBEEF);
        repeat (4) @(posedge clk);
        #1;
        dRef  = done32;
        rst32 = 1'b1;
        #1;
        check("midrst_valid32",  64'(if32.SC_RegSHIFTTX_Valid_Out),  64'd0);
        check("midrst_ready32",  64'(if32.SC_RegSHIFTTX_Ready_Out),  64'd1);
        check("midrst_serial32", 64'(if32.SC_RegSHIFTTX_Serial_Out), 64'd0);
        check("midrst_data32",   64'(if32.SC_RegSHIFTTX_DataBUS_Out), 64'h0);
        expQ32.delete();
        repeat (2) @(posedge clk);
        #1;
        rst32 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_done", 64'(done32), 64'(dRef));
        send32(32'h0F0F00F1);
        waitDone(32);
        #1;
        check("midrst_recover_done", 64'(done32), 64'(dRef + 1));

        // Back-to-back with Load held high
        @(posedge clk); #1;
        dRef = done32;
        if32.SC_RegSHIFTTX_DataBUS_In  = 32'h80000000;
        if32.SC_RegSHIFTTX_Load_InHigh = 1'b1;
        push32(32'h80000000);
        push32(32'h00000001);
        @(posedge clk); #1;
        if32.SC_RegSHIFTTX_DataBUS_In = 32'h00000001;
        waitDone(32);
        @(posedge clk); #1;
        check("b2b_gap_ready", 64'(if32.SC_RegSHIFTTX_Ready_Out), 64'd1);
        check("b2b_gap_valid", 64'(if32.SC_RegSHIFTTX_Valid_Out), 64'd0);
        @(posedge clk); #1;
        check("b2b_restart_valid", 64'(if32.SC_RegSHIFTTX_Valid_Out), 64'd1);
        if32.SC_RegSHIFTTX_Load_InHigh = 1'b0;
        waitDone(32);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_done_count", 64'(done32), 64'(dRef + 2));

        // 8-bit instance: C3 -> 1,1,0,0,0,0,1,1
        @(posedge clk); #1;
        if8.SC_RegSHIFTTX_DataBUS_In  = 8'hC3;
        if8.SC_RegSHIFTTX_Load_InHigh = 1'b1;
        expQ8.push_back(1'b1); expQ8.push_back(1'b1);
        expQ8.push_back(1'b0); expQ8.push_back(1'b0);
        expQ8.push_back(1'b0); expQ8.push_back(1'b0);
        expQ8.push_back(1'b1); expQ8.push_back(1'b1);
        @(posedge clk); #1;
        if8.SC_RegSHIFTTX_Load_InHigh = 1'b0;
        waitDone(8);
        #1;
        check("done_data8", 64'(if8.SC_RegSHIFTTX_DataBUS_Out), 64'h00);
        repeat (5) @(posedge clk);
        #1;
        check("done_count8", 64'(done8), 64'd1);
        check("q8_empty", 64'(expQ8.size()), 64'd0);
        check("q32_empty", 64'(expQ32.size()), 64'd0);
        check("done_count32_total", 64'(done32), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
